// File: rtl/variable_latency_divider.sv
// Signed DVD_W-by-DVS_W sequential restoring divider, one quotient bit per cycle.
// Truncating division: the quotient rounds toward zero and the remainder takes the dividend's sign.
// A divide by zero yields quotient all-ones, remainder = dividend[DVS_W-1:0] and raises div_by_zero.
//
// Optional build macro VLDIV_EARLY_TERM_EN: when defined, the dividend's leading zeros are skipped
// and the iteration count is DVD_W - clz(|dividend|). When undefined, every nonzero-divisor
// operation iterates DVD_W times. Results are the same in both builds.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   loaded       start request; operands are sampled on the edge that starts the operation
//   dividend     signed dividend (DVD_W)
//   divisor      signed divisor (DVS_W)
//   quotient     signed quotient, registered (DVD_W)
//   remainder    signed remainder, registered (DVS_W)
//   completed    result valid; held until loaded is sampled low
//   busy         operation in progress
//   div_by_zero  last operation had divisor == 0
module variable_latency_divider #(
  parameter int unsigned DVD_W = 32,
  parameter int unsigned DVS_W = 16,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loaded,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             completed,
  output logic             busy,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] DvdWCnt = CNT_W'(DVD_W);

  typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

  state_e           state_q, state_d;
  // dvd_q holds the aligned dividend magnitude; quotient bits fill in from the LSB as it shifts.
  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W:0]   prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic             dbz_q, dbz_d;
  logic [DVD_W-1:0] quot_q, quot_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic             dbz_out_q, dbz_out_d;

  logic [DVD_W-1:0] dvd_mag, dvd_aligned;
  logic [DVS_W-1:0] dvs_mag, rem_mag;
  logic [CNT_W-1:0] len;
  logic [DVS_W:0]   prem_sh, diff;
  logic             ge;

  assign dvd_mag = dividend[DVD_W-1] ? -dividend : dividend;
  assign dvs_mag = divisor[DVS_W-1] ? -divisor : divisor;

`ifdef VLDIV_EARLY_TERM_EN
  logic [CNT_W-1:0] lz;

  // Highest set bit wins, so the last match in the ascending scan sets the count.
  always_comb begin
    lz = DvdWCnt;
    for (int i = 0; i < DVD_W; i++) begin
      if (dvd_mag[i]) lz = CNT_W'(DVD_W - 1 - i);
    end
  end

  assign len         = DvdWCnt - lz;
  assign dvd_aligned = dvd_mag << lz;
`else
  assign len         = DvdWCnt;
  assign dvd_aligned = dvd_mag;
`endif

  // The top bit of prem_q is always clear after an iteration; folding it into the compare keeps
  // the restoring step correct even if it were not.
  assign prem_sh = {prem_q[DVS_W-1:0], dvd_q[DVD_W-1]};
  assign diff    = prem_sh - {1'b0, dvs_q};
  assign ge      = prem_q[DVS_W] | (prem_sh >= {1'b0, dvs_q});
  assign rem_mag = prem_q[DVS_W-1:0];

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    qsign_d   = qsign_q;
    rsign_d   = rsign_q;
    dbz_d     = dbz_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_out_d = dbz_out_q;
    unique case (state_q)
      StIdle: begin
        if (loaded) begin
          qsign_d = dividend[DVD_W-1] ^ divisor[DVS_W-1];
          rsign_d = dividend[DVD_W-1];
          dvs_d   = dvs_mag;
          prem_d  = '0;
          cnt_d   = len;
          if (divisor == '0) begin
            // Keep the raw dividend so its low bits can be returned as the remainder.
            dbz_d   = 1'b1;
            dvd_d   = dividend;
            state_d = StFix;
          end else begin
            dbz_d   = 1'b0;
            dvd_d   = dvd_aligned;
            state_d = (len == '0) ? StFix : StIter;
          end
        end
      end
      StIter: begin
        dvd_d  = {dvd_q[DVD_W-2:0], ge};
        prem_d = ge ? diff : prem_sh;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        if (dbz_q) begin
          quot_d = '1;
          rem_d  = dvd_q[DVS_W-1:0];
        end else begin
          quot_d = qsign_q ? -dvd_q : dvd_q;
          rem_d  = rsign_q ? -rem_mag : rem_mag;
        end
        dbz_out_d = dbz_q;
        state_d   = StDone;
      end
      StDone: begin
        if (!loaded) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dvd_q     <= '0;
      dvs_q     <= '0;
      prem_q    <= '0;
      cnt_q     <= '0;
      qsign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      prem_q    <= prem_d;
      cnt_q     <= cnt_d;
      qsign_q   <= qsign_d;
      rsign_q   <= rsign_d;
      dbz_q     <= dbz_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_out_q;
  assign completed   = (state_q == StDone);
  assign busy        = (state_q == StIter) || (state_q == StFix);

endmodule

// File: tb/tb_variable_latency_divider.sv
// Directed bench for variable_latency_divider: signed results, latency, divide by zero,
// handshake hold-off and asynchronous reset abort.
module tb_variable_latency_divider;

  logic        clk;
  logic        rst_n;
  logic        loaded;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        completed;
  logic        busy;
  logic        div_by_zero;

  int n_tests;
  int n_fail;

  variable_latency_divider #(
    .DVD_W(32),
    .DVS_W(16),
    .CNT_W(6)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .loaded     (loaded),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .completed  (completed),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected edges from the start edge to completed, given the significant-bit count.
  function automatic int exp_lat(input int sig_bits);
`ifdef VLDIV_EARLY_TERM_EN
    return sig_bits + 1;
`else
    return 33;
`endif
  endfunction

  // Present operands, pass the start edge, then scramble operands to show they are not re-read.
  task automatic start_op(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input bit hold);
    @(negedge clk);
    loaded   = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    check({tag, ".busy_at_start"}, 32'(busy), 32'd1);
    check({tag, ".completed_at_start"}, 32'(completed), 32'd0);
    if (!hold) loaded = 1'b0;
    dividend = 32'hDEAD_BEEF;
    divisor  = 16'h0000;
  endtask

  task automatic wait_done(input string tag, input int lat, input logic [31:0] q,
                           input logic [15:0] r, input logic dbz);
    int cycles;
    cycles = 0;
    while (cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
      if (completed) break;
    end
    check({tag, ".latency"}, 32'(cycles), 32'(lat));
    check({tag, ".quotient"}, quotient, q);
    check({tag, ".remainder"}, 32'(remainder), 32'(r));
    check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(dbz));
    check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [15:0] b, input int lat,
                     input logic [31:0] q, input logic [15:0] r, input logic dbz);
    start_op(tag, a, b, 1'b0);
    wait_done(tag, lat, q, r, dbz);
    @(posedge clk);
    #1;
    check({tag, ".completed_clears"}, 32'(completed), 32'd0);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    loaded   = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.quotient", quotient, 32'd0);
    check("reset.remainder", 32'(remainder), 32'd0);
    check("reset.completed", 32'(completed), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run("p100_d7",   32'd100,         16'd7,      exp_lat(7),  32'd14,        16'd2,    1'b0);
    run("n100_d7",   32'hFFFF_FF9C,   16'd7,      exp_lat(7),  32'hFFFF_FFF2, 16'hFFFE, 1'b0);
    run("p100_dn7",  32'd100,         16'hFFF9,   exp_lat(7),  32'hFFFF_FFF2, 16'd2,    1'b0);
    run("n7_d2",     32'hFFFF_FFF9,   16'd2,      exp_lat(3),  32'hFFFF_FFFD, 16'hFFFF, 1'b0);
    run("min_dn1",   32'h8000_0000,   16'hFFFF,   exp_lat(32), 32'h8000_0000, 16'd0,    1'b0);
    run("max_d1",    32'h7FFF_FFFF,   16'd1,      exp_lat(31), 32'h7FFF_FFFF, 16'd0,    1'b0);
    run("p40000_dmin", 32'd40000,     16'h8000,   exp_lat(16), 32'hFFFF_FFFF, 16'h1C40, 1'b0);
    run("dbz_5",     32'd5,           16'd0,      1,           32'hFFFF_FFFF, 16'd5,    1'b1);
    run("zero_d3",   32'd0,           16'd3,      exp_lat(0),  32'd0,         16'd0,    1'b0);

    // Loaded held high through DONE must not restart the divider.
    start_op("hold", 32'd100, 16'd7, 1'b1);
    wait_done("hold", exp_lat(7), 32'd14, 16'd2, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("hold.completed_stays", 32'(completed), 32'd1);
    check("hold.busy_stays_low", 32'(busy), 32'd0);
    @(negedge clk);
    loaded = 1'b0;
    @(posedge clk);
    #1;
    check("hold.completed_clears", 32'(completed), 32'd0);
    run("p1000_d10", 32'd1000, 16'd10, exp_lat(10), 32'd100, 16'd0, 1'b0);

    // Asynchronous reset mid-iteration aborts and clears the registered results.
    start_op("abort", 32'd65535, 16'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("abort.busy_mid", 32'(busy), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.quotient", quotient, 32'd0);
    check("abort.remainder", 32'(remainder), 32'd0);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.completed", 32'(completed), 32'd0);
    check("abort.div_by_zero", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort.no_result", 32'(completed), 32'd0);
    run("p65535_d3", 32'd65535, 16'd3, exp_lat(16), 32'd21845, 16'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/variable_latency_divider.md
Name: variable_latency_divider

Overview:
- Signed 32-bit by 16-bit integer divider producing quotient and remainder.
- Sequential restoring division on operand magnitudes, one quotient bit per cycle.
- Latency varies with the dividend's significant-bit count; leading zero bits are skipped.
- Inverse companion to the team's variable-latency multiplier; uses the same loaded/completed handshake style.

Parameters:
- DVD_W, 32, dividend and quotient width (signed).
- DVS_W, 16, divisor and remainder width (signed).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DVD_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- loaded  input  1  start request; operands valid while high.
- dividend  input  DVD_W  signed dividend.
- divisor  input  DVS_W  signed divisor.
- quotient  output  DVD_W  signed quotient, registered.
- remainder  output  DVS_W  signed remainder, registered.
- completed  output  1  result valid.
- busy  output  1  high in ITER and FIX.
- div_by_zero  output  1  last operation had divisor == 0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: all outputs 0, state IDLE, internal registers 0. Reset asserted mid-operation aborts immediately. No result is produced afterwards; loaded must be re-sampled.
- States: IDLE, ITER, FIX, DONE.
- IDLE, at the edge where loaded=1 (edge N):
  - Latch sign_q = sign(dividend) XOR sign(divisor) and sign_r = sign(dividend).
  - Latch |dividend| as a DVD_W-bit unsigned value and |divisor| as a DVS_W-bit unsigned value. |-2^31| = 0x80000000 unsigned.
  - Compute L = DVD_W - clz(|dividend|). L = 0 when dividend = 0.
  - Pre-shift the magnitude left by clz so its MSB is aligned. Clear the partial remainder.
  - Next state: if divisor == 0, FIX with the dbz flag set; else if L == 0, FIX; else ITER with cnt = L.
  - busy=1 and completed=0 from edge N.
- ITER, each edge:
  - prem = {prem, next dividend bit}, using a DVS_W+1-bit working register.
  - If prem >= |divisor|: subtract and shift in quotient bit 1; else shift in 0.
  - cnt decrements. Leave for FIX on the edge where cnt reaches 0. Exactly L ITER edges.
- FIX, one edge:
  - quotient = sign_q ? -q_mag : q_mag, modulo 2^DVD_W. -2^31 / -1 gives 0x80000000.
  - remainder = sign_r ? -r_mag : r_mag. Truncating division: the remainder takes the dividend's sign, and |remainder| < |divisor|.
  - Divide by zero: quotient = all ones, remainder = dividend[DVS_W-1:0], div_by_zero = 1; otherwise div_by_zero = 0.
  - completed=1 and busy=0 at this edge; go to DONE.
- Latency: completed rises after edge N+L+1 (N+1 when L=0 or divide by zero).
- DONE: outputs held. When loaded is sampled 0, completed clears and the state returns to IDLE. loaded held high keeps the block in DONE, so there is no auto-restart.
- loaded is ignored in ITER and FIX. Operand changes after edge N have no effect.
- quotient, remainder and div_by_zero keep their last values until the next FIX.

Optional Feature:
- Macro: VLDIV_EARLY_TERM_EN.
- Defined: leading-zero skip as above; L = DVD_W - clz(|dividend|).
- Undefined: no clz logic; L = DVD_W always and there is no pre-shift. Latency is fixed at N+DVD_W+1 for a nonzero divisor, and results are identical. Divide by zero still completes at N+1.

Test Plan:
- 100 / 7 -> quotient 14, remainder 2, completed after N+8 (L=7); with the macro undefined, N+33.
- -100 / 7 -> quotient -14 (0xFFFFFFF2), remainder -2 (0xFFFE); 100 / -7 -> quotient -14, remainder 2.
- -2147483648 / -1 -> quotient 0x80000000, remainder 0, completed after N+33. 0x7FFFFFFF / 1 -> quotient 0x7FFFFFFF, completed after N+32.
- 5 / 0 -> quotient 0xFFFFFFFF, remainder 5, div_by_zero=1, completed after N+1. A following 0 / 3 gives quotient 0, remainder 0, div_by_zero=0, completed after N+1.
- Handshake: loaded held high through DONE gives no restart. Drop loaded for one cycle and completed clears. Re-raise loaded with 1000 / 10 and the result is quotient 100, remainder 0.
- Drop rst_n during ITER of 65535 / 3 -> all outputs 0 immediately and the state is IDLE. A new start after release gives quotient 21845, remainder 0.
